nasti_lite_write_arbiter: RTL and testbench
===========================================

Name: nasti_lite_write_arbiter

Overview:
- Shares one downstream NASTI write port between NUM_MASTER upstream NASTI masters; the downstream port feeds the nasti-lite write buffer.
- Grants one master per transaction, covering the AW, W and B phases. Round-robin by default.
- Serialises whole write transactions, so the buffer sees only one burst in flight and B is routed back without ID remapping.

Parameters:
NUM_MASTER, 2, number of upstream masters (>=1)
ID_WIDTH, 1, AW/B id width
ADDR_WIDTH, 8, address width
DATA_WIDTH, 8, W data width (multiple of 8)
USER_WIDTH, 1, user field width (>0)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
m_aw_id/addr/len/size/user  input  NUM_MASTER x field width (len 8, size 3)  per-master AW payload
m_aw_valid  input  NUM_MASTER  per-master AW valid
m_aw_ready  output  NUM_MASTER  per-master AW ready
m_w_data/strb/last/user  input  NUM_MASTER x field width  per-master W payload
m_w_valid  input  NUM_MASTER  W valid
m_w_ready  output  NUM_MASTER  W ready
m_b_id/resp/user  output  ID_WIDTH/2/USER_WIDTH (shared bus)  B payload, broadcast to all masters
m_b_valid  output  NUM_MASTER  B valid, one-hot to the granted master
m_b_ready  input  NUM_MASTER  B ready
s_aw_id/addr/len/size/user, s_aw_valid  output  field width, 1  downstream AW
s_aw_ready  input  1  downstream AW ready
s_w_data/strb/last/user, s_w_valid  output  field width, 1  downstream W
s_w_ready  input  1  downstream W ready
s_b_id/resp/user, s_b_valid  input  field width, 1  downstream B
s_b_ready  output  1  downstream B ready
grant_o  output  GW=max(1,$clog2(NUM_MASTER))  current grant index, debug
busy_o  output  1  high when state != IDLE

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0. All valid/ready outputs 0; busy_o=0.
- Payload outputs are muxed from the granted master; their value is don't-care while the matching valid is low.
- IDLE:
  - All readys and valids low.
  - If any m_aw_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Register grant; go to AW next cycle. This gives a 1-cycle arbitration bubble.
  - No request: stay in IDLE.
- AW:
  - s_aw_* = m_aw_*[grant]; m_aw_ready[grant] = s_aw_ready, combinationally.
  - On s_aw_valid && s_aw_ready, go to W.
  - Non-granted m_aw_ready are held 0.
- W:
  - s_w_* = m_w_*[grant]; m_w_ready[grant] = s_w_ready.
  - On a W handshake with s_w_last=1, go to B. Other beats stay in W.
  - W from any master is never accepted before its AW (readys 0 outside W).
- B:
  - s_b_ready = m_b_ready[grant]; m_b_valid[grant] = s_b_valid.
  - On B handshake: go to IDLE, rr_ptr = (grant+1) mod NUM_MASTER.
  - An s_b_valid arriving in any other state is held off (s_b_ready=0).
- Simultaneous requests: round-robin. After master k completes, master k+1 has top priority.
- A master dropping m_aw_valid while in AW is a protocol violation. It is not detected; s_aw_valid follows the input.
- NUM_MASTER=1: grant is fixed at 0; the FSM is unchanged, bubble included.
- Reset asserted mid-transaction: immediate return to reset values. In-flight downstream state is not recovered; downstream shares the same reset.
- No combinational path from any m_*_valid to s_*_ready.

Optional Feature:
NASTI_WRITE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. rr_ptr is removed and the search always starts at 0.
- Undefined: round-robin as above.

Decomposition:
- Package nasti_arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_AW, ARB_W, ARB_B} arb_state_t
  - NASTI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
- Sub-module nasti_rr_arbiter (NUM_REQ):
  - Inputs: req vector, ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Combinational only; reused by the read-side arbiter.

Test Plan:
- Single master 0, AW addr=0x10 len=3, 4 W beats, s_aw_ready/s_w_ready always 1:
  - s_aw_valid rises 1 cycle after m_aw_valid[0].
  - 4 beats pass through, the last with s_w_last=1.
  - s_b resp=0 is routed to m_b_valid[0] only; busy_o falls the cycle after the B handshake.
- Masters 0 and 1 request in the same cycle, repeated 4 transactions:
  - grant_o sequence is 0,1,0,1.
  - With NASTI_WRITE_ARB_FIXED_PRIO_EN defined and both kept requesting: 0,0,0,0.
- Master 1 drives W beats before its AW is granted:
  - m_w_ready[1] stays 0 until state=W with grant=1; no data reaches s_w_*.
- Backpressure, s_w_ready toggling 1,0,1,0 over a len=1 burst:
  - Each beat is held stable until accepted.
  - m_w_ready[grant] mirrors s_w_ready exactly.
- rstn pulsed low during W after 2 of 4 beats:
  - All valids/readys go to 0 asynchronously; grant=0; busy_o=0.
  - After release, a new master-1 request is granted normally.
- Downstream B with resp=2'b10 and m_b_ready[0] low for 3 cycles:
  - m_b_valid[0] is held high with resp=SLVERR and s_b_ready=0 throughout.
  - Completion occurs on the first cycle m_b_ready[0]=1.

Source files
------------

// File: rtl/nasti_arb_pkg.sv
// Shared types and constants for the nasti-lite read/write arbiters.
package nasti_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_AW, ARB_W, ARB_B} arb_state_t;

    localparam logic [1:0] NASTI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] NASTI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] NASTI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] NASTI_RESP_DECERR = 2'b11;

    // Grant index width; a single requester still gets a 1-bit index.
    function automatic int arbIdxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nasti_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or above ptr, with wrap.
module nasti_rr_arbiter
    import nasti_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [arbIdxWidth(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [arbIdxWidth(NUM_REQ)-1:0] gnt_idx_o,
    output logic                            any_o
);

    localparam int GW = arbIdxWidth(NUM_REQ);

    // Scan from farthest to nearest so the request closest to ptr wins last.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx[GW-1:0];
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nasti_lite_write_arbiter.sv
// Serialises whole write transactions from NUM_MASTER masters onto one NASTI write port.
// Define NASTI_WRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module nasti_lite_write_arbiter
    import nasti_arb_pkg::*;
#(
    parameter int NUM_MASTER = 2,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [NUM_MASTER-1:0][ID_WIDTH-1:0]     m_aw_id,
    input  logic [NUM_MASTER-1:0][ADDR_WIDTH-1:0]   m_aw_addr,
    input  logic [NUM_MASTER-1:0][7:0]              m_aw_len,
    input  logic [NUM_MASTER-1:0][2:0]              m_aw_size,
    input  logic [NUM_MASTER-1:0][USER_WIDTH-1:0]   m_aw_user,
    input  logic [NUM_MASTER-1:0]                   m_aw_valid,
    output logic [NUM_MASTER-1:0]                   m_aw_ready,
    input  logic [NUM_MASTER-1:0][DATA_WIDTH-1:0]   m_w_data,
    input  logic [NUM_MASTER-1:0][DATA_WIDTH/8-1:0] m_w_strb,
    input  logic [NUM_MASTER-1:0]                   m_w_last,
    input  logic [NUM_MASTER-1:0][USER_WIDTH-1:0]   m_w_user,
    input  logic [NUM_MASTER-1:0]                   m_w_valid,
    output logic [NUM_MASTER-1:0]                   m_w_ready,
    output logic [ID_WIDTH-1:0]                     m_b_id,
    output logic [1:0]                              m_b_resp,
    output logic [USER_WIDTH-1:0]                   m_b_user,
    output logic [NUM_MASTER-1:0]                   m_b_valid,
    input  logic [NUM_MASTER-1:0]                   m_b_ready,
    output logic [ID_WIDTH-1:0]                     s_aw_id,
    output logic [ADDR_WIDTH-1:0]                   s_aw_addr,
    output logic [7:0]                              s_aw_len,
    output logic [2:0]                              s_aw_size,
    output logic [USER_WIDTH-1:0]                   s_aw_user,
    output logic                                    s_aw_valid,
    input  logic                                    s_aw_ready,
    output logic [DATA_WIDTH-1:0]                   s_w_data,
    output logic [DATA_WIDTH/8-1:0]                 s_w_strb,
    output logic                                    s_w_last,
    output logic [USER_WIDTH-1:0]                   s_w_user,
    output logic                                    s_w_valid,
    input  logic                                    s_w_ready,
    input  logic [ID_WIDTH-1:0]                     s_b_id,
    input  logic [1:0]                              s_b_resp,
    input  logic [USER_WIDTH-1:0]                   s_b_user,
    input  logic                                    s_b_valid,
    output logic                                    s_b_ready,
    output logic [arbIdxWidth(NUM_MASTER)-1:0]      grant_o,
    output logic                                    busy_o
);

    localparam int             GW   = arbIdxWidth(NUM_MASTER);
    localparam logic [GW-1:0]  LAST = GW'(NUM_MASTER - 1);

    arb_state_t              state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [NUM_MASTER-1:0]   grantOh_q, grantOh_d;
    logic [GW-1:0]           searchPtr;
    logic [NUM_MASTER-1:0]   arbGnt;
    logic [GW-1:0]           arbIdx;
    logic                    arbAny;
    logic                    inAw, inW, inB;

`ifdef NASTI_WRITE_ARB_FIXED_PRIO_EN
    assign searchPtr = '0;
`else
    logic [GW-1:0] rrPtr_q, rrPtr_d;
    assign searchPtr = rrPtr_q;
`endif

    nasti_rr_arbiter #(.NUM_REQ(NUM_MASTER)) u_arb (
        .req_i     (m_aw_valid),
        .ptr_i     (searchPtr),
        .gnt_o     (arbGnt),
        .gnt_idx_o (arbIdx),
        .any_o     (arbAny)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            grantOh_q <= '0;
`ifndef NASTI_WRITE_ARB_FIXED_PRIO_EN
            rrPtr_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            grantOh_q <= grantOh_d;
`ifndef NASTI_WRITE_ARB_FIXED_PRIO_EN
            rrPtr_q   <= rrPtr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        grantOh_d = grantOh_q;
`ifndef NASTI_WRITE_ARB_FIXED_PRIO_EN
        rrPtr_d   = rrPtr_q;
`endif
        case (state_q)
            ARB_IDLE: if (arbAny) begin
                state_d   = ARB_AW;
                grant_d   = arbIdx;
                grantOh_d = arbGnt;
            end
            ARB_AW: if (s_aw_valid && s_aw_ready) state_d = ARB_W;
            ARB_W:  if (s_w_valid && s_w_ready && s_w_last) state_d = ARB_B;
            ARB_B:  if (s_b_valid && s_b_ready) begin
                state_d = ARB_IDLE;
`ifndef NASTI_WRITE_ARB_FIXED_PRIO_EN
                rrPtr_d = (grant_q == LAST) ? '0 : grant_q + GW'(1);
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign inAw = (state_q == ARB_AW);
    assign inW  = (state_q == ARB_W);
    assign inB  = (state_q == ARB_B);

    // Handshake routing is phase-gated, so stray W or B traffic is held off.
    assign s_aw_valid = inAw & m_aw_valid[grant_q];
    assign m_aw_ready = {NUM_MASTER{inAw & s_aw_ready}} & grantOh_q;
    assign s_w_valid  = inW & m_w_valid[grant_q];
    assign m_w_ready  = {NUM_MASTER{inW & s_w_ready}} & grantOh_q;
    assign s_b_ready  = inB & m_b_ready[grant_q];
    assign m_b_valid  = {NUM_MASTER{inB & s_b_valid}} & grantOh_q;

    assign s_aw_id   = m_aw_id[grant_q];
    assign s_aw_addr = m_aw_addr[grant_q];
    assign s_aw_len  = m_aw_len[grant_q];
    assign s_aw_size = m_aw_size[grant_q];
    assign s_aw_user = m_aw_user[grant_q];
    assign s_w_data  = m_w_data[grant_q];
    assign s_w_strb  = m_w_strb[grant_q];
    assign s_w_last  = m_w_last[grant_q];
    assign s_w_user  = m_w_user[grant_q];
    assign m_b_id    = s_b_id;
    assign m_b_resp  = s_b_resp;
    assign m_b_user  = s_b_user;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_nasti_lite_write_arbiter.sv
// Directed bench for nasti_lite_write_arbiter (two masters); honours NASTI_WRITE_ARB_FIXED_PRIO_EN.
module tb_nasti_lite_write_arbiter;
    import nasti_arb_pkg::*;

    localparam int NM = 2;

    logic              clk, rstn;
    logic [NM-1:0][0:0] m_aw_id, m_aw_user, m_w_strb, m_w_user;
    logic [NM-1:0][7:0] m_aw_addr, m_aw_len, m_w_data;
    logic [NM-1:0][2:0] m_aw_size;
    logic [NM-1:0]      m_aw_valid, m_aw_ready, m_w_last, m_w_valid, m_w_ready;
    logic [NM-1:0]      m_b_valid, m_b_ready;
    logic [0:0]         m_b_id, m_b_user, s_aw_id, s_aw_user, s_w_strb, s_w_user;
    logic [0:0]         s_b_id, s_b_user, grant_o;
    logic [1:0]         m_b_resp, s_b_resp;
    logic [7:0]         s_aw_addr, s_aw_len, s_w_data;
    logic [2:0]         s_aw_size;
    logic               s_aw_valid, s_aw_ready, s_w_last, s_w_valid, s_w_ready;
    logic               s_b_valid, s_b_ready, busy_o;

    int compared   = 0;
    int mismatched = 0;

    nasti_lite_write_arbiter dut (
        .clk(clk), .rstn(rstn),
        .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
        .m_aw_size(m_aw_size), .m_aw_user(m_aw_user),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_w_user(m_w_user), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_user(m_b_user),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_user(s_aw_user),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_w_user(s_w_user), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_user(s_b_user),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // W beat 'beat' of an nBeats burst on every master; master m carries data m*16+beat.
    task automatic applyStimulus(input int beat, input int nBeats, input logic [NM-1:0] wValid);
        m_w_valid = wValid;
        for (int m = 0; m < NM; m++) begin
            m_w_data[m] = 8'(m * 16 + beat);
            m_w_strb[m] = 1'b1;
            m_w_last[m] = (beat == nBeats - 1);
            m_w_user[m] = 1'b0;
        end
        #1;
    endtask

    task automatic setAw(input logic [NM-1:0] req, input int len);
        m_aw_valid = req;
        for (int m = 0; m < NM; m++) begin
            m_aw_addr[m] = 8'(8'h40 + m * 16);
            m_aw_len[m]  = 8'(len);
        end
    endtask

    // Whole transaction from IDLE; W is offered early on both masters to prove it is held off.
    task automatic runTxn(input int expGrant, input int nBeats, input logic [NM-1:0] awReq);
        logic [31:0] oh;
        oh = 32'(1) << expGrant;
        s_aw_ready = 1'b1;
        s_w_ready  = 1'b1;
        m_b_ready  = '1;
        setAw(awReq, nBeats - 1);
        applyStimulus(0, nBeats, '1);
        checkOutput("idle s_aw_valid", 32'(s_aw_valid), 0);
        checkOutput("idle m_w_ready", 32'(m_w_ready), 0);
        checkOutput("idle s_w_valid", 32'(s_w_valid), 0);
        stepCycle();
        #1;
        checkOutput("aw grant_o", 32'(grant_o), 32'(expGrant));
        checkOutput("aw s_aw_valid", 32'(s_aw_valid), 1);
        checkOutput("aw s_aw_addr", 32'(s_aw_addr), 32'(8'h40 + expGrant * 16));
        checkOutput("aw s_aw_len", 32'(s_aw_len), 32'(nBeats - 1));
        checkOutput("aw m_aw_ready", 32'(m_aw_ready), oh);
        checkOutput("aw m_w_ready", 32'(m_w_ready), 0);
        checkOutput("aw s_w_valid", 32'(s_w_valid), 0);
        stepCycle();
        s_b_valid = 1'b1;
        s_b_resp  = NASTI_RESP_OKAY;
        for (int b = 0; b < nBeats; b++) begin
            applyStimulus(b, nBeats, '1);
            checkOutput("w m_aw_ready", 32'(m_aw_ready), 0);
            checkOutput("w s_w_data", 32'(s_w_data), 32'(expGrant * 16 + b));
            checkOutput("w s_w_last", 32'(s_w_last), 32'(b == nBeats - 1));
            checkOutput("w m_w_ready", 32'(m_w_ready), oh);
            checkOutput("w early s_b_ready", 32'(s_b_ready), 0);
            checkOutput("w early m_b_valid", 32'(m_b_valid), 0);
            stepCycle();
        end
        m_w_valid = '0;
        #1;
        checkOutput("b m_w_ready", 32'(m_w_ready), 0);
        checkOutput("b m_b_valid", 32'(m_b_valid), oh);
        checkOutput("b m_b_resp", 32'(m_b_resp), 32'(NASTI_RESP_OKAY));
        checkOutput("b s_b_ready", 32'(s_b_ready), 1);
        checkOutput("b busy_o", 32'(busy_o), 1);
        stepCycle();
        s_b_valid = 1'b0;
        #1;
        checkOutput("done busy_o", 32'(busy_o), 0);
    endtask

    initial begin
        int expG;
        rstn = 1'b0;
        m_aw_id = '0; m_aw_user = '0; m_aw_size = '0; m_w_strb = '0; m_w_user = '0;
        m_aw_addr = '0; m_aw_len = '0; m_w_data = '0; m_w_last = '0;
        m_aw_valid = '0; m_w_valid = '0; m_b_ready = '0;
        s_aw_ready = 1'b0; s_w_ready = 1'b0;
        s_b_valid = 1'b0; s_b_id = '0; s_b_resp = '0; s_b_user = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst busy_o", 32'(busy_o), 0);
        checkOutput("rst grant_o", 32'(grant_o), 0);
        checkOutput("rst s_aw_valid", 32'(s_aw_valid), 0);
        checkOutput("rst m_aw_ready", 32'(m_aw_ready), 0);
        rstn = 1'b1;
        stepCycle();

        $display("[TB] single master 0, four beats");
        runTxn(0, 4, 2'b01);

        $display("[TB] master 1 offers W before its AW");
        runTxn(1, 2, 2'b10);

        $display("[TB] both masters request continuously");
        for (int t = 0; t < 4; t++) begin
`ifdef NASTI_WRITE_ARB_FIXED_PRIO_EN
            expG = 0;
`else
            expG = t % 2;
`endif
            runTxn(expG, 1, 2'b11);
        end
        m_aw_valid = '0;
        stepCycle();

        $display("[TB] W backpressure and B hold with SLVERR");
        setAw(2'b01, 1);
        s_aw_ready = 1'b1;
        m_b_ready  = '0;
        stepCycle();
        stepCycle();
        m_aw_valid = '0;
        s_w_ready  = 1'b1;
        applyStimulus(0, 2, 2'b01);
        checkOutput("bp beat0 m_w_ready", 32'(m_w_ready), 1);
        checkOutput("bp beat0 s_w_data", 32'(s_w_data), 0);
        stepCycle();
        s_w_ready = 1'b0;
        applyStimulus(1, 2, 2'b01);
        checkOutput("bp stall m_w_ready", 32'(m_w_ready), 0);
        checkOutput("bp stall s_w_valid", 32'(s_w_valid), 1);
        checkOutput("bp stall s_w_data", 32'(s_w_data), 1);
        stepCycle();
        s_w_ready = 1'b1;
        #1;
        checkOutput("bp beat1 m_w_ready", 32'(m_w_ready), 1);
        checkOutput("bp beat1 s_w_data", 32'(s_w_data), 1);
        checkOutput("bp beat1 s_w_last", 32'(s_w_last), 1);
        stepCycle();
        m_w_valid = '0;
        s_w_ready = 1'b0;
        s_b_valid = 1'b1;
        s_b_resp  = NASTI_RESP_SLVERR;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("bhold m_b_valid", 32'(m_b_valid), 1);
            checkOutput("bhold m_b_resp", 32'(m_b_resp), 32'(NASTI_RESP_SLVERR));
            checkOutput("bhold s_b_ready", 32'(s_b_ready), 0);
            checkOutput("bhold busy_o", 32'(busy_o), 1);
            stepCycle();
        end
        m_b_ready = 2'b01;
        #1;
        checkOutput("bhold release s_b_ready", 32'(s_b_ready), 1);
        stepCycle();
        s_b_valid = 1'b0;
        #1;
        checkOutput("bhold done busy_o", 32'(busy_o), 0);

        $display("[TB] reset in the middle of a W burst");
        setAw(2'b01, 3);
        s_aw_ready = 1'b1;
        s_w_ready  = 1'b1;
        stepCycle();
        stepCycle();
        m_aw_valid = '0;
        for (int b = 0; b < 2; b++) begin
            applyStimulus(b, 4, 2'b01);
            stepCycle();
        end
        applyStimulus(2, 4, 2'b01);
        checkOutput("pre-rst m_w_ready", 32'(m_w_ready), 1);
        rstn = 1'b0;
        #1;
        checkOutput("mid-rst s_w_valid", 32'(s_w_valid), 0);
        checkOutput("mid-rst m_w_ready", 32'(m_w_ready), 0);
        checkOutput("mid-rst m_aw_ready", 32'(m_aw_ready), 0);
        checkOutput("mid-rst s_b_ready", 32'(s_b_ready), 0);
        checkOutput("mid-rst grant_o", 32'(grant_o), 0);
        checkOutput("mid-rst busy_o", 32'(busy_o), 0);
        m_w_valid = '0;
        stepCycle();
        rstn = 1'b1;
        stepCycle();
        runTxn(1, 2, 2'b10);
        m_aw_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
